// File: rtl/core_data_resp_mem_if.sv
// Core data port: request fields driven by the master, grant and response by the slave.
interface core_data_resp_mem_if;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
    logic [3:0]  be;
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, data, be, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, data, be, output gnt, r_data, r_valid);
endinterface

// File: rtl/core_data_resp_mem.sv
// Responder for the core data port: word-addressed local memory with a fixed-latency,
// strictly in-order response pipeline and a sticky out-of-range error flag.
module core_data_resp_mem #(
    parameter int          NB_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] ERR_RDATA = 32'hBADC_AB1E
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    core_data_resp_mem_if.slave  bus,
    input  logic                 stall_i,
    output logic                 err_o,
    output logic [2:0]           outstanding_o
);

    localparam int          IDX_W = $clog2(NB_WORDS);
    localparam logic [31:0] SPAN  = 32'(NB_WORDS * 4);

    logic                        hs_s;
    logic                        in_range_s;
    logic                        wr_s;
    logic [31:0]                 off_s;
    logic [IDX_W-1:0]            idx_s;
    logic [31:0]                 rd_s;
    logic [31:0]                 load_data_s;

    logic [31:0]                 mem_r [NB_WORDS];
    logic [LATENCY-1:0]          pipe_valid_r;
    logic [LATENCY-1:0][31:0]    pipe_data_r;
    logic                        err_r;
    logic [2:0]                  outstanding_r;

    assign bus.gnt = bus.req & ~stall_i & ~rst_i;

    // Handshake qualification and address decode; the subtraction makes addresses below the base wrap out of range.
    always_comb begin
        hs_s        = 1'b0;
        off_s       = 32'h0;
        in_range_s  = 1'b0;
        idx_s       = {IDX_W{1'b0}};
        rd_s        = ERR_RDATA;
        wr_s        = 1'b0;
        load_data_s = 32'h0;

        hs_s       = bus.req & bus.gnt;
        off_s      = bus.add - BASE_ADDR;
        in_range_s = (off_s < SPAN);
        idx_s      = off_s[2 +: IDX_W];
        if (in_range_s) begin
            rd_s = mem_r[idx_s];
        end else begin
            rd_s = ERR_RDATA;
        end
        wr_s = hs_s & ~bus.wen & in_range_s;
        if (hs_s && bus.wen) begin
            load_data_s = rd_s;
        end else begin
            load_data_s = 32'h0;
        end
    end

    // Byte-enabled memory write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be[b]) begin
                    mem_r[idx_s][8*b +: 8] <= bus.data[8*b +: 8];
                end
            end
        end
    end

    // Response shift register: one {valid, data} slot per cycle of latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid_r <= {LATENCY{1'b0}};
            pipe_data_r  <= {LATENCY{32'h0}};
        end else begin
            pipe_valid_r[0] <= hs_s;
            pipe_data_r[0]  <= load_data_s;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_data_r[i]  <= pipe_data_r[i-1];
            end
        end
    end

    // Sticky error flag and in-flight counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r         <= 1'b0;
            outstanding_r <= 3'd0;
        end else begin
            if (hs_s && !in_range_s) begin
                err_r <= 1'b1;
            end
            outstanding_r <= outstanding_r + {2'b00, hs_s} - {2'b00, pipe_valid_r[LATENCY-1]};
        end
    end

    // Response drive; masked during reset so a flushed slot never shows up in the reset cycle.
    always_comb begin
        bus.r_valid = 1'b0;
        bus.r_data  = 32'h0;
        if (rst_i) begin
            bus.r_valid = 1'b0;
            bus.r_data  = 32'h0;
        end else begin
            bus.r_valid = pipe_valid_r[LATENCY-1];
            bus.r_data  = pipe_data_r[LATENCY-1];
        end
    end

    assign err_o         = err_r;
    assign outstanding_o = outstanding_r;

endmodule

// File: tb/tb_core_data_resp_mem.sv
// Directed bench: three responders (latency 1, 3, 2) exercised in sequence with hand-computed expectations.
module tb_core_data_resp_mem;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] stall_v;
    wire        err1, err3, err2;
    wire  [2:0] out1, out3, out2;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    core_data_resp_mem_if b1 ();
    core_data_resp_mem_if b3 ();
    core_data_resp_mem_if b2 ();

    core_data_resp_mem #(.LATENCY(1)) u_l1 (.clk_i(clk), .rst_i(rst_v[0]), .bus(b1), .stall_i(stall_v[0]),
                                            .err_o(err1), .outstanding_o(out1));
    core_data_resp_mem #(.LATENCY(3)) u_l3 (.clk_i(clk), .rst_i(rst_v[1]), .bus(b3), .stall_i(stall_v[1]),
                                            .err_o(err3), .outstanding_o(out3));
    core_data_resp_mem #(.LATENCY(2)) u_l2 (.clk_i(clk), .rst_i(rst_v[2]), .bus(b2), .stall_i(stall_v[2]),
                                            .err_o(err2), .outstanding_o(out2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic req, input logic wen, input logic [31:0] add,
                         input logic [31:0] data, input logic [3:0] be);
        case (s)
            0: begin b1.req = req; b1.wen = wen; b1.add = add; b1.data = data; b1.be = be; end
            1: begin b3.req = req; b3.wen = wen; b3.add = add; b3.data = data; b3.be = be; end
            2: begin b2.req = req; b2.wen = wen; b2.add = add; b2.data = data; b2.be = be; end
            default: ;
        endcase
    endtask

    function automatic logic get_gnt(input int s);
        case (s)
            0: return b1.gnt;
            1: return b3.gnt;
            default: return b2.gnt;
        endcase
    endfunction

    function automatic logic get_rv(input int s);
        case (s)
            0: return b1.r_valid;
            1: return b3.r_valid;
            default: return b2.r_valid;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int s);
        case (s)
            0: return b1.r_data;
            1: return b3.r_data;
            default: return b2.r_data;
        endcase
    endfunction

    task automatic idle(input int s);
        drive(s, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    endtask

    // Full transaction: wait (bounded) for grant, then for the response; entered and left just after a rising edge.
    task automatic xfer(input int s, input logic wen, input logic [31:0] add, input logic [31:0] data,
                        input logic [3:0] be, output logic [31:0] rdata);
        logic ok;
        rdata = 32'h0;
        ok = 1'b0;
        drive(s, 1'b1, wen, add, data, be);
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (get_gnt(s)) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("xfer_gnt_seen", {31'h0, ok}, 32'h1);
        @(posedge clk); #1;
        idle(s);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (get_rv(s)) begin ok = 1'b1; rdata = get_rd(s); end
            @(posedge clk); #1;
        end
        chk("xfer_rsp_seen", {31'h0, ok}, 32'h1);
    endtask

    initial begin
        rst_v   = 3'b111;
        stall_v = 3'b000;
        idle(0); idle(1); idle(2);
        drive(0, 1'b1, 1'b1, BASE + 32'd8, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_gnt", {31'h0, b1.gnt}, 32'h0);
        chk("rst_rvalid", {31'h0, b1.r_valid}, 32'h0);
        chk("rst_rdata", b1.r_data, 32'h0);
        chk("rst_err", {31'h0, err1}, 32'h0);
        chk("rst_out", {29'h0, out1}, 32'h0);
        chk("rst_out_l3", {29'h0, out3}, 32'h0);

        // Latency 1: write then immediate read of the same word
        @(posedge clk); #1;
        rst_v = 3'b000;
        drive(0, 1'b1, 1'b0, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        chk("wr_gnt", {31'h0, b1.gnt}, 32'h1);
        chk("wr_rv_early", {31'h0, b1.r_valid}, 32'h0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, BASE + 32'd8, 32'h0, 4'h0);
        @(negedge clk);
        chk("rd_gnt", {31'h0, b1.gnt}, 32'h1);
        chk("wr_rv", {31'h0, b1.r_valid}, 32'h1);
        chk("wr_rdata", b1.r_data, 32'h0);
        chk("wr_out", {29'h0, out1}, 32'h1);
        @(posedge clk); #1;
        idle(0);
        @(negedge clk);
        chk("rd_rv", {31'h0, b1.r_valid}, 32'h1);
        chk("rd_rdata", b1.r_data, 32'hDEAD_BEEF);
        chk("rd_out", {29'h0, out1}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_rv", {31'h0, b1.r_valid}, 32'h0);
        chk("idle_rdata", b1.r_data, 32'h0);
        chk("idle_out", {29'h0, out1}, 32'h0);
        @(posedge clk); #1;

        // Partial and no-op writes
        xfer(0, 1'b0, BASE + 32'd12, 32'h1122_3344, 4'hF, rd);
        xfer(0, 1'b0, BASE + 32'd12, 32'hAABB_CCDD, 4'b0101, rd);
        chk("pw_rsp_zero", rd, 32'h0);
        xfer(0, 1'b1, BASE + 32'd12, 32'h0, 4'h0, rd);
        chk("pw_read", rd, 32'h11BB_33DD);
        xfer(0, 1'b0, BASE + 32'd12, 32'h0, 4'h0, rd);
        xfer(0, 1'b1, BASE + 32'd12, 32'h0, 4'h0, rd);
        chk("be0_read", rd, 32'h11BB_33DD);

        // Stall holds off the grant
        stall_v[0] = 1'b1;
        drive(0, 1'b1, 1'b0, BASE + 32'd12, 32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_gnt", {31'h0, b1.gnt}, 32'h0);
            chk("stall_rv", {31'h0, b1.r_valid}, 32'h0);
            chk("stall_out", {29'h0, out1}, 32'h0);
            @(posedge clk); #1;
        end
        stall_v[0] = 1'b0;
        @(negedge clk);
        chk("unstall_gnt", {31'h0, b1.gnt}, 32'h1);
        @(posedge clk); #1;
        idle(0);
        @(negedge clk);
        chk("unstall_rv", {31'h0, b1.r_valid}, 32'h1);
        @(posedge clk); #1;
        xfer(0, 1'b1, BASE + 32'd12, 32'h0, 4'h0, rd);
        chk("unstall_read", rd, 32'hFFFF_FFFF);

        // Out-of-range accesses
        xfer(0, 1'b0, BASE, 32'h0A0A_0A0A, 4'hF, rd);
        xfer(0, 1'b0, BASE + 32'd4092, 32'h7777_7777, 4'hF, rd);
        chk("oor_err_pre", {31'h0, err1}, 32'h0);
        drive(0, 1'b1, 1'b1, BASE + 32'd4096, 32'h0, 4'h0);
        @(negedge clk);
        chk("oor_gnt", {31'h0, b1.gnt}, 32'h1);
        chk("oor_err_same", {31'h0, err1}, 32'h0);
        @(posedge clk); #1;
        idle(0);
        @(negedge clk);
        chk("oor_rv", {31'h0, b1.r_valid}, 32'h1);
        chk("oor_rdata", b1.r_data, 32'hBADC_AB1E);
        chk("oor_err", {31'h0, err1}, 32'h1);
        @(posedge clk); #1;
        xfer(0, 1'b0, BASE + 32'd4096, 32'h1234_5678, 4'hF, rd);
        xfer(0, 1'b0, BASE - 32'd4, 32'h9999_9999, 4'hF, rd);
        xfer(0, 1'b1, BASE, 32'h0, 4'h0, rd);
        chk("oor_wr_base", rd, 32'h0A0A_0A0A);
        xfer(0, 1'b1, BASE + 32'd4092, 32'h0, 4'h0, rd);
        chk("oor_wr_top", rd, 32'h7777_7777);
        chk("oor_err_sticky", {31'h0, err1}, 32'h1);

        // Latency 3 streaming
        for (int k = 0; k < 8; k++) begin
            xfer(1, 1'b0, BASE + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 4'hF, rd);
        end
        drive(1, 1'b1, 1'b1, BASE, 32'h0, 4'h0);
        for (int n = 0; n < 13; n++) begin
            int hs_done;
            int rsp_done;
            @(negedge clk);
            hs_done  = (n < 8) ? n : 8;
            rsp_done = (n < 3) ? 0 : ((n - 3 > 8) ? 8 : n - 3);
            chk("st_gnt", {31'h0, b3.gnt}, (n < 8) ? 32'h1 : 32'h0);
            chk("st_rv", {31'h0, b3.r_valid}, (n >= 3 && n <= 10) ? 32'h1 : 32'h0);
            chk("st_rdata", b3.r_data, (n >= 3 && n <= 10) ? 32'hC0DE_0000 + 32'(n - 3) : 32'h0);
            chk("st_out", {29'h0, out3}, 32'(hs_done - rsp_done));
            @(posedge clk); #1;
            if (n + 1 < 8) drive(1, 1'b1, 1'b1, BASE + 32'(4 * (n + 1)), 32'h0, 4'h0);
            else idle(1);
        end

        // Latency 2: reset with two reads in flight
        xfer(2, 1'b0, BASE + 32'd4, 32'h600D_F00D, 4'hF, rd);
        xfer(2, 1'b1, BASE + 32'd4096, 32'h0, 4'h0, rd);
        chk("l2_oor_rdata", rd, 32'hBADC_AB1E);
        chk("l2_err_set", {31'h0, err2}, 32'h1);
        drive(2, 1'b1, 1'b1, BASE + 32'd4, 32'h0, 4'h0);
        @(negedge clk);
        chk("mf_gnt1", {31'h0, b2.gnt}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mf_gnt2", {31'h0, b2.gnt}, 32'h1);
        chk("mf_rv_early", {31'h0, b2.r_valid}, 32'h0);
        chk("mf_out1", {29'h0, out2}, 32'h1);
        @(posedge clk); #1;
        idle(2);
        rst_v[2] = 1'b1;
        @(negedge clk);
        chk("mf_rst_rv", {31'h0, b2.r_valid}, 32'h0);
        chk("mf_rst_rdata", b2.r_data, 32'h0);
        @(posedge clk); #1;
        rst_v[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mf_post_rv", {31'h0, b2.r_valid}, 32'h0);
            chk("mf_post_out", {29'h0, out2}, 32'h0);
            chk("mf_post_err", {31'h0, err2}, 32'h0);
            @(posedge clk); #1;
        end
        xfer(2, 1'b1, BASE + 32'd4, 32'h0, 4'h0, rd);
        chk("mf_mem_kept", rd, 32'h600D_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_data_resp_mem.md
Name: core_data_resp_mem

Overview:
- Responder end of the cluster core data port.
- Accepts `core_data_req_t` requests from a core or master and returns `core_data_rsp_t` responses from a local word-addressed memory.
- Response latency is configurable; responses are strictly in order.
- Used as a TCDM or scratchpad stand-in behind a core's data port and as the reference slave in core-level benches.

Parameters:
- NB_WORDS, 1024, memory depth in 32-bit words (power of 2, ≥2).
- BASE_ADDR, 32'h1000_0000, byte address of word 0 (aligned to NB_WORDS*4).
- LATENCY, 1, cycles from the grant edge to the `r_valid` cycle (1..4).
- ERR_RDATA, 32'hBADC_AB1E, read data returned for out-of-range reads.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  70  `core_data_req_t` {req, add[31:0], wen, data[31:0], be[3:0]}
- rsp_o  out  34  `core_data_rsp_t` {gnt, r_data[31:0], r_valid}
- stall_i  in  1  forces gnt=0 while high (bench or arbitration throttle)
- err_o  out  1  sticky flag, set on any out-of-range access
- outstanding_o  out  3  number of granted requests not yet answered (0..LATENCY)

Behaviour:
- Single clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - gnt=0 while rst_i=1.
  - r_valid=0, r_data=0.
  - err_o=0, outstanding_o=0.
  - All response pipeline stages invalid.
  - Memory contents are not reset.
- Grant:
  - gnt = req & ~stall_i & ~rst_i, combinational.
  - No dependency on r_valid: the consumer always accepts responses.
  - A handshake occurs in any cycle with req & gnt.
  - Requester holds add/wen/data/be stable until gnt (requester's rule; not checked here).
- Address decode:
  - off = add − BASE_ADDR.
  - In range iff off < NB_WORDS*4.
  - Index = off[2 +: log2(NB_WORDS)]; add[1:0] ignored.
- Write (wen=0) at handshake:
  - In range: update mem[index] bytes where be[i]=1 at that clock edge.
  - be=0 is a legal no-op write.
  - Out of range: memory untouched, err_o←1.
- Read (wen=1) at handshake:
  - Read data is sampled at that edge from pre-write contents (read-before-write).
  - Out of range: data = ERR_RDATA, err_o←1.
- Responses:
  - Every handshake, read or write, produces exactly one r_valid pulse.
  - A handshake at edge t gives r_valid=1 in the cycle following edge t+LATENCY−1. With LATENCY=1 that is the cycle immediately after the grant cycle.
  - Response pipeline is a LATENCY-deep shift register of {valid, data}.
  - r_data = read data for reads, 0 for writes. r_data=0 whenever r_valid=0.
  - Back-to-back handshakes each cycle give back-to-back r_valid, in order.
- outstanding_o:
  - +1 on handshake, −1 on r_valid cycle; both in the same cycle leaves it unchanged.
  - Never exceeds LATENCY.
- Hazards: a write at edge t followed by a read of the same word at edge t+1 returns the new data.
- err_o: clears only on rst_i.
- Reset mid-operation: in-flight responses are dropped (r_valid never asserted for them); outstanding_o→0; memory writes already committed persist.

Test Plan:
- LATENCY=1: write add=BASE+8, data=32'hDEAD_BEEF, be=4'hF; then read BASE+8 → gnt in each request cycle, write r_valid with r_data=0, read r_valid with r_data=32'hDEAD_BEEF one cycle after its grant.
- Partial write: preload 32'h1122_3344, write data=32'hAABB_CCDD be=4'b0101, read back → 32'h11BB_33DD.
- Streaming, LATENCY=3: 8 consecutive reads of BASE..BASE+28 → 8 consecutive r_valid cycles starting 3 cycles after the first grant, data in address order, outstanding_o peaks at 3.
- stall_i high for 4 cycles with req held → gnt=0, no r_valid, memory unchanged; first gnt in the cycle stall_i drops.
- Out-of-range: read BASE+NB_WORDS*4 → r_data=32'hBADC_AB1E, err_o=1 from the next cycle and stays high. Out-of-range write leaves memory intact.
- Reset mid-flight, LATENCY=2: issue 2 reads, assert rst_i the cycle after the second grant → no r_valid for either read, outstanding_o=0, err_o=0; earlier written data still readable after reset.
